// File: rtl/change_dispense_ctrl.sv
// change_dispense_ctrl
// Pays out change from two coin hoppers (high and low value), one coin at a
// time. Coins are picked greedily (high first). After each eject pulse the
// controller waits for the exit sensor before choosing the next coin. It
// tracks hopper inventory, reports the unpaid remainder, and latches a jam
// flag if the sensor does not acknowledge in time.
//
// Ports:
//   clk, rst             clock; asynchronous active-high reset
//   req_valid/req_amount change request handshake (amount in units)
//   req_ready            high only while idle
//   coin_seen            exit-sensor pulse, one per coin
//   refill               operator refill / jam clear (IDLE or JAM only)
//   eject_hi/eject_lo    one-cycle release pulses
//   busy, done           request in progress / one-cycle completion pulse
//   shortfall            unpaid units, updated at each done
//   jam                  sticky jam flag
//   hi_cnt/lo_cnt        hopper inventories
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | waiting for a request; refill reloads hoppers
// SELECT   | choose next coin, or finish with the remainder as shortfall
// EJECT    | one-cycle eject pulse on the chosen hopper
// WAIT_ACK | wait for coin_seen; timeout declares a jam
// DONE     | one-cycle done pulse
// JAM      | stuck until refill
module change_dispense_ctrl #(
  parameter int COIN_HI = 10,
  parameter int COIN_LO = 5,
  parameter int HI_INIT = 8,
  parameter int LO_INIT = 8,
  parameter int TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  input  logic [5:0] req_amount,
  output logic       req_ready,
  input  logic       coin_seen,
  input  logic       refill,
  output logic       eject_hi,
  output logic       eject_lo,
  output logic       busy,
  output logic       done,
  output logic [5:0] shortfall,
  output logic       jam,
  output logic [3:0] hi_cnt,
  output logic [3:0] lo_cnt
);

  localparam logic [5:0] HI_VAL = 6'(COIN_HI);
  localparam logic [5:0] LO_VAL = 6'(COIN_LO);
  localparam logic [3:0] HI_RST = 4'(HI_INIT);
  localparam logic [3:0] LO_RST = 4'(LO_INIT);
  localparam logic [7:0] TO_VAL = 8'(TIMEOUT);

  typedef enum logic [2:0] {
    IDLE,
    SELECT,
    EJECT,
    WAIT_ACK,
    DONE,
    JAM
  } state_t;

  state_t     state;
  logic [5:0] remaining;
  logic       coin_is_hi;
  logic [7:0] timer;

  // Direct decodes of the state register, so they change only on clock edges.
  assign req_ready = (state == IDLE);
  assign busy      = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      remaining  <= '0;
      coin_is_hi <= 1'b0;
      timer      <= '0;
      eject_hi   <= 1'b0;
      eject_lo   <= 1'b0;
      done       <= 1'b0;
      shortfall  <= '0;
      jam        <= 1'b0;
      hi_cnt     <= HI_RST;
      lo_cnt     <= LO_RST;
    end else begin
      eject_hi <= 1'b0;
      eject_lo <= 1'b0;
      done     <= 1'b0;
      case (state)
        IDLE: begin
          // Refill wins over a simultaneous request; the request is simply
          // not taken this cycle.
          if (refill) begin
            hi_cnt <= HI_RST;
            lo_cnt <= LO_RST;
            jam    <= 1'b0;
          end else if (req_valid) begin
            remaining <= req_amount;
            state     <= SELECT;
          end
        end
        SELECT: begin
          // Eject pulses are registered here so they appear during EJECT.
          if (remaining >= HI_VAL && hi_cnt != 4'd0) begin
            coin_is_hi <= 1'b1;
            eject_hi   <= 1'b1;
            state      <= EJECT;
          end else if (remaining >= LO_VAL && lo_cnt != 4'd0) begin
            coin_is_hi <= 1'b0;
            eject_lo   <= 1'b1;
            state      <= EJECT;
          end else begin
            shortfall <= remaining;
            done      <= 1'b1;
            state     <= DONE;
          end
        end
        EJECT: begin
          timer <= '0;
          state <= WAIT_ACK;
        end
        WAIT_ACK: begin
          // An acknowledge in the final timeout cycle still counts.
          if (coin_seen) begin
            if (coin_is_hi) begin
              remaining <= remaining - HI_VAL;
              hi_cnt    <= hi_cnt - 4'd1;
            end else begin
              remaining <= remaining - LO_VAL;
              lo_cnt    <= lo_cnt - 4'd1;
            end
            state <= SELECT;
          end else if (timer == TO_VAL) begin
            jam       <= 1'b1;
            shortfall <= remaining;
            done      <= 1'b1;
            state     <= DONE;
          end else begin
            timer <= timer + 8'd1;
          end
        end
        DONE: begin
          state <= jam ? JAM : IDLE;
        end
        JAM: begin
          if (refill) begin
            hi_cnt <= HI_RST;
            lo_cnt <= LO_RST;
            jam    <= 1'b0;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_change_dispense_ctrl.sv
// Directed testbench for change_dispense_ctrl (default parameters).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_change_dispense_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid;
  logic [5:0] req_amount;
  logic       req_ready;
  logic       coin_seen;
  logic       refill;
  logic       eject_hi;
  logic       eject_lo;
  logic       busy;
  logic       done;
  logic [5:0] shortfall;
  logic       jam;
  logic [3:0] hi_cnt;
  logic [3:0] lo_cnt;

  int n_chk  = 0;
  int n_pass = 0;

  // Per-request observations filled in by do_req.
  logic [31:0] seq;
  logic [5:0]  last_sf;
  int          last_cycles;
  int          rdy_seen;
  logic        got_done;

  change_dispense_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_amount (req_amount),
    .req_ready  (req_ready),
    .coin_seen  (coin_seen),
    .refill     (refill),
    .eject_hi   (eject_hi),
    .eject_lo   (eject_lo),
    .busy       (busy),
    .done       (done),
    .shortfall  (shortfall),
    .jam        (jam),
    .hi_cnt     (hi_cnt),
    .lo_cnt     (lo_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Issue one request and follow it to done. ack_dly<0 means never acknowledge.
  // Eject history is packed two bits per coin: 2'b10 high, 2'b01 low.
  task automatic do_req(input logic [5:0] amt, input int ack_dly,
                        input bit hold_valid, input bit hold_refill);
    int cnt;
    seq = '0; rdy_seen = 0; got_done = 1'b0; last_sf = '0; last_cycles = 0;
    req_valid = 1'b1; req_amount = amt;
    @(negedge clk);
    req_valid = hold_valid;
    refill    = hold_refill;
    cnt = -1;
    for (int i = 0; i < 300; i++) begin
      if (done) begin
        last_sf = shortfall; last_cycles = i + 1; got_done = 1'b1;
        break;
      end
      if (req_ready) rdy_seen++;
      if (eject_hi || eject_lo) begin
        seq = (seq << 2) | {30'd0, eject_hi, eject_lo};
        cnt = ack_dly;
      end
      coin_seen = (cnt == 0);
      if (cnt >= 0) cnt--;
      @(negedge clk);
    end
    req_valid = 1'b0; refill = 1'b0; coin_seen = 1'b0;
    @(negedge clk);
    chk("done_one_cycle", done, 0);
  endtask

  task automatic req_and_check(input string tag, input logic [5:0] amt, input int ack_dly,
                               input bit hv, input bit hr, input logic [31:0] e_seq,
                               input int e_sf, input int e_cyc, input int e_hi,
                               input int e_lo, input int e_jam);
    do_req(amt, ack_dly, hv, hr);
    chk({tag, " done_seen"}, got_done, 1);
    chk({tag, " ejects"}, seq, e_seq);
    chk({tag, " shortfall"}, last_sf, e_sf);
    chk({tag, " cycles"}, last_cycles, e_cyc);
    chk({tag, " ready_while_busy"}, rdy_seen, 0);
    chk({tag, " hi_cnt"}, hi_cnt, e_hi);
    chk({tag, " lo_cnt"}, lo_cnt, e_lo);
    chk({tag, " jam"}, jam, e_jam);
  endtask

  initial begin
    int ej;
    rst = 1'b1; req_valid = 1'b0; req_amount = '0; coin_seen = 1'b0; refill = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst req_ready", req_ready, 1);
    chk("rst busy", busy, 0);
    chk("rst done", done, 0);
    chk("rst jam", jam, 0);
    chk("rst shortfall", shortfall, 0);
    chk("rst ejects", {eject_hi, eject_lo}, 0);
    chk("rst hi_cnt", hi_cnt, 8);
    chk("rst lo_cnt", lo_cnt, 8);

    // coin_seen while idle is ignored
    coin_seen = 1'b1; @(negedge clk); coin_seen = 1'b0; @(negedge clk);
    chk("idle_coin hi_cnt", hi_cnt, 8);
    chk("idle_coin lo_cnt", lo_cnt, 8);
    chk("idle_coin ready", req_ready, 1);

    //             tag     amt ack hv hr seq          sf cyc hi lo jam
    req_and_check("r25",   25,  2, 0, 0, 32'h29,       0, 14, 6, 7, 0);
    req_and_check("r17",   17,  2, 1, 0, 32'h9,        2, 10, 5, 6, 0);
    req_and_check("r0",     0,  2, 0, 0, 32'h0,        0,  2, 5, 6, 0);
    req_and_check("r20to", 20, -1, 0, 0, 32'h2,       20, 19, 5, 6, 1);

    // now in JAM: requests refused, no ejects
    ej = 0;
    req_valid = 1'b1; req_amount = 6'd10;
    for (int i = 0; i < 3; i++) begin
      chk("jam req_ready", req_ready, 0);
      chk("jam busy", busy, 1);
      if (eject_hi || eject_lo) ej++;
      @(negedge clk);
    end
    req_valid = 1'b0;
    chk("jam no_eject", ej, 0);
    refill = 1'b1; @(negedge clk); refill = 1'b0;
    chk("jam_refill jam", jam, 0);
    chk("jam_refill ready", req_ready, 1);
    chk("jam_refill busy", busy, 0);
    chk("jam_refill hi_cnt", hi_cnt, 8);
    chk("jam_refill lo_cnt", lo_cnt, 8);

    // deplete the high hopper, then fall back to low coins
    req_and_check("r60",   60,  1, 0, 0, 32'hAAA,      0, 20, 2, 8, 0);
    req_and_check("r10a",  10,  1, 0, 0, 32'h2,        0,  5, 1, 8, 0);
    req_and_check("r30",   30,  1, 0, 0, 32'h255,      0, 17, 0, 4, 0);
    req_and_check("r10lo", 10,  1, 0, 0, 32'h5,        0,  8, 0, 2, 0);

    refill = 1'b1; @(negedge clk); refill = 1'b0;
    chk("idle_refill hi_cnt", hi_cnt, 8);
    chk("idle_refill lo_cnt", lo_cnt, 8);

    // refill held through a request is ignored; ack on the last timeout cycle counts
    req_and_check("r10rf", 10,  3, 0, 1, 32'h2,        0,  7, 7, 8, 0);
    req_and_check("r10tc", 10, 16, 0, 0, 32'h2,        0, 20, 6, 8, 0);
    req_and_check("r3",     3,  1, 0, 0, 32'h0,        3,  2, 6, 8, 0);

    // asynchronous reset in WAIT_ACK
    req_valid = 1'b1; req_amount = 6'd25;
    @(negedge clk); req_valid = 1'b0;
    @(negedge clk);
    chk("pre_rst eject_hi", eject_hi, 1);
    @(negedge clk);
    chk("pre_rst busy", busy, 1);
    #1 rst = 1'b1;
    #2 rst = 1'b0;
    @(negedge clk);
    chk("post_rst ready", req_ready, 1);
    chk("post_rst busy", busy, 0);
    chk("post_rst jam", jam, 0);
    chk("post_rst shortfall", shortfall, 0);
    chk("post_rst hi_cnt", hi_cnt, 8);
    chk("post_rst lo_cnt", lo_cnt, 8);
    ej = 0;
    for (int i = 0; i < 5; i++) begin
      if (eject_hi || eject_lo) ej++;
      @(negedge clk);
    end
    chk("post_rst no_eject", ej, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/change_dispense_ctrl.md
Name: change_dispense_ctrl

Overview:
- Sequences the physical payout of change from two coin hoppers: high-value coins (10 units) and low-value coins (5 units).
- Accepts a change amount from the vending core, which returns change in units, and picks coins greedily.
- Pulses one hopper at a time and waits for the exit-sensor acknowledge before the next coin.
- Tracks hopper inventory, reports any unpaid shortfall, and flags a jam on acknowledge timeout.

Parameters:
- COIN_HI, 10: value of a high hopper coin, in units.
- COIN_LO, 5: value of a low hopper coin, in units.
- HI_INIT, 8: high hopper count loaded at reset and on refill (max 15).
- LO_INIT, 8: low hopper count loaded at reset and on refill (max 15).
- TIMEOUT, 15: WAIT_ACK cycles allowed before a jam is declared (max 255).

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- req_valid  in  1  change request valid
- req_amount  in  6  change amount in units
- req_ready  out  1  controller can accept a request
- coin_seen  in  1  exit sensor: one coin passed (single-cycle pulse)
- refill  in  1  hoppers refilled and jam cleared by the operator
- eject_hi  out  1  one-cycle pulse: release one high coin
- eject_lo  out  1  one-cycle pulse: release one low coin
- busy  out  1  request in progress, or jammed
- done  out  1  one-cycle pulse: request finished
- shortfall  out  6  units not paid; valid while done=1, held until the next done
- jam  out  1  sticky jam flag
- hi_cnt  out  4  high hopper inventory
- lo_cnt  out  4  low hopper inventory

Behaviour:
- States: IDLE, SELECT, EJECT, WAIT_ACK, DONE, JAM. Registers: remaining (6b), coin_is_hi, timer (8b).
- Reset values:
  - state IDLE; req_ready=1.
  - eject_hi, eject_lo, busy, done, jam = 0; shortfall=0; remaining=0; timer=0.
  - hi_cnt=HI_INIT; lo_cnt=LO_INIT.
- req_ready=1 only in IDLE. busy=1 in every state except IDLE.
- IDLE:
  - On req_valid && req_ready, latch remaining=req_amount and go to SELECT.
  - req_amount=0 is accepted; it reaches DONE via SELECT with shortfall 0.
- SELECT (one cycle), in priority order:
  - remaining>=COIN_HI && hi_cnt>0: coin_is_hi=1, go to EJECT.
  - else remaining>=COIN_LO && lo_cnt>0: coin_is_hi=0, go to EJECT.
  - else go to DONE with shortfall=remaining. This covers remaining below COIN_LO, non-multiples of 5, and empty hoppers.
- EJECT (one cycle):
  - Drive eject_hi or eject_lo for exactly one cycle, per coin_is_hi.
  - Clear timer; go to WAIT_ACK.
- WAIT_ACK:
  - coin_seen=1: subtract the coin value from remaining, decrement the matching hopper count, go to SELECT.
  - Else timer increments. When timer==TIMEOUT with no coin_seen: set jam=1, shortfall=remaining, go to DONE.
  - coin_seen in the same cycle as timer==TIMEOUT counts as the acknowledge, not a jam.
- DONE (one cycle): done=1. Go to JAM if jam=1, otherwise to IDLE.
- JAM: req_ready=0, busy=1. Held until refill=1, then go to IDLE.
- Refill:
  - Honoured only in IDLE or JAM.
  - Reloads hi_cnt=HI_INIT and lo_cnt=LO_INIT, clears jam, and goes to IDLE the next cycle.
  - Ignored in SELECT, EJECT, WAIT_ACK and DONE.
- coin_seen outside WAIT_ACK is ignored: no count change, no state change.
- Hopper counts never wrap. A zero-count hopper is never selected.
- Arithmetic: remaining is 6-bit unsigned. Subtraction happens only after a >= check, so it never underflows.
- Latency: acceptance cycle N, SELECT N+1, eject pulse N+2. The earliest coin_seen is sampled at N+3. Each further coin takes at least 3 cycles.
- An asynchronous rst in any state, including mid-WAIT_ACK, forces all reset values. The in-flight request is discarded.

Test Plan:
- Amount 25, hoppers 8/8, coin_seen 2 cycles after each eject → pulses hi, hi, lo; done with shortfall=0; hi_cnt=6, lo_cnt=7.
- Amount 17 → pulses hi, lo; done with shortfall=2. Amount 0 → done 2 cycles after acceptance, shortfall=0, no ejects.
- HI_INIT=1, amount 30 → one hi pulse then four lo pulses; hi_cnt=0, lo_cnt=4, shortfall=0. A second request of 10 → two lo pulses.
- Amount 20, no coin_seen after the first eject → done at timeout with jam=1, shortfall=20. Then req_ready=0, busy=1, and req_valid is not accepted. refill → jam=0, counts reloaded, req_ready=1.
- Boundaries:
  - coin_seen in IDLE: counts unchanged.
  - req_valid while busy: not accepted.
  - refill during WAIT_ACK: counts unchanged.
  - coin_seen exactly at timer==TIMEOUT: counted, no jam.
- rst pulsed during WAIT_ACK of a 25-unit request → next cycle: IDLE, req_ready=1, counts at INIT, jam=0, shortfall=0, no eject pulse.
